// File: rtl/ram_byte_ctrl.sv
// Byte-serial load/store sequencer for the byte-wide data RAM.
// Splits a 32-bit LSU request into little-endian byte accesses and returns one extended response.
module ram_byte_ctrl #(
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [31:0]       rsp_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [7:0]        ram_wdata,
  output logic              ram_re,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [7:0]        ram_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state, state_nxt;
  logic              we_q, uns_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [1:0]        idx;
  logic [31:0]       asm_q, asm_nxt, ext;
  logic              illegal, last;
  logic [ADDR_W-1:0] acc_addr;

  assign illegal = (req_size == 2'b11)
                || (req_size == 2'b01 && req_addr[0])
                || (req_size == 2'b10 && req_addr[1:0] != 2'b00);

  assign last = (size_q == 2'b00)
             || (size_q == 2'b01 && idx == 2'd1)
             || (size_q == 2'b10 && idx == 2'd3);

  // Legal requests are aligned, so OR-ing the byte index never needs a carry.
  assign acc_addr = {addr_q[ADDR_W-1:2], addr_q[1:0] | idx};

  always_comb begin
    asm_nxt = asm_q;
    asm_nxt[{idx, 3'b000} +: 8] = ram_rdata;
  end

  always_comb begin
    case (size_q)
      2'b00:   ext = {{24{~uns_q & asm_nxt[7]}},  asm_nxt[7:0]};
      2'b01:   ext = {{16{~uns_q & asm_nxt[15]}}, asm_nxt[15:0]};
      default: ext = asm_nxt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = illegal ? RESP : ACCESS;
      ACCESS:  if (last)      state_nxt = RESP;
      RESP:                   state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Response registers default to zero so they only carry data during RESP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      size_q    <= 2'b00;
      addr_q    <= '0;
      wdata_q   <= '0;
      idx       <= 2'd0;
      asm_q     <= '0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      case (state)
        IDLE: if (req_valid) begin
          we_q    <= req_we;
          uns_q   <= req_unsigned;
          size_q  <= req_size;
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          idx     <= 2'd0;
          asm_q   <= '0;
          rsp_err <= illegal;
        end
        ACCESS: begin
          idx <= idx + 2'd1;
          if (!we_q) asm_q <= asm_nxt;
          if (last && !we_q) rsp_rdata <= ext;
        end
        default: ;
      endcase
    end
  end

  assign req_ready = rst_n && (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign ram_we    = rst_n && (state == ACCESS) && we_q;
  assign ram_re    = rst_n && (state == ACCESS) && !we_q;
  assign ram_waddr = acc_addr;
  assign ram_raddr = acc_addr;
  assign ram_wdata = wdata_q[{idx, 3'b000} +: 8];

endmodule
